// File: rtl/seg_unscan.sv
// seg_unscan: samples a scanned 6-digit 7-segment bus and publishes decoded, coherent frames.
// Build option SEG_UNSCAN_SYNC_EN adds a 2-flop synchronizer ahead of the input register.
module seg_unscan #(
    parameter int          STABLE_CYC  = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_data,
    output logic [23:0] digit_val,
    output logic [5:0]  digit_dp,
    output logic [5:0]  digit_err,
    output logic        frame_valid,
    output logic        sel_err,
    output logic        stall
);
    localparam int            DW        = $clog2(STABLE_CYC + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYC);
    localparam logic [DW-1:0] DWELL_CAP = DW'(STABLE_CYC - 1);

    logic [5:0]    sel_in;
    logic [7:0]    data_in;
    logic [5:0]    sel_q;
    logic [7:0]    data_q;
    logic [5:0]    sel_prev;
    logic [DW-1:0] dwell;
    logic [5:0]    mask;
    logic [7:0]    pattern [6];
    logic [31:0]   tmo_cnt;
    logic          capture;
    logic          store;
    logic          illegal;
    logic          complete;
    logic [23:0]   dec_val;
    logic [5:0]    dec_dp;
    logic [5:0]    dec_err;

`ifdef SEG_UNSCAN_SYNC_EN
    logic [5:0] sel_s1, sel_s2;
    logic [7:0] data_s1, data_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1  <= 6'h3F;
            sel_s2  <= 6'h3F;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            sel_s1  <= seg_sel;
            sel_s2  <= sel_s1;
            data_s1 <= seg_data;
            data_s2 <= data_s1;
        end
    end

    assign sel_in  = sel_s2;
    assign data_in = data_s2;
`else
    assign sel_in  = seg_sel;
    assign data_in = seg_data;
`endif

    // Input register resets to the idle (nothing selected) code so the first real select counts as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 6'h3F;
            data_q   <= 8'h00;
            sel_prev <= 6'h3F;
            dwell    <= '0;
        end else begin
            sel_q    <= sel_in;
            data_q   <= data_in;
            sel_prev <= sel_q;
            if (sel_q != sel_prev)
                dwell <= '0;
            else if (dwell != DWELL_MAX)
                dwell <= dwell + DW'(1);
        end
    end

    assign capture  = (sel_q == sel_prev) && (dwell == DWELL_CAP);
    assign store    = capture && $onehot(~sel_q);
    assign illegal  = capture && !$onehot(~sel_q);
    assign complete = (mask == 6'h3F);

    // Clear-then-set ordering lets a capture in the completion cycle seed the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) pattern[i] <= 8'h00;
            mask <= 6'h00;
        end else begin
            for (int i = 0; i < 6; i++)
                if (store && !sel_q[i]) pattern[i] <= data_q;
            mask <= (complete ? 6'h00 : mask) | (store ? ~sel_q : 6'h00);
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h46:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
            default: decode = 5'h1F;
        endcase
    endfunction

    always_comb begin
        dec_val = '0;
        dec_dp  = '0;
        dec_err = '0;
        for (int i = 0; i < 6; i++) begin
            {dec_err[i], dec_val[4*i +: 4]} = decode(pattern[i][6:0]);
            dec_dp[i] = ~pattern[i][7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val   <= '0;
            digit_dp    <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            frame_valid <= complete;
            sel_err     <= illegal;
            if (complete) begin
                digit_val <= dec_val;
                digit_dp  <= dec_dp;
                digit_err <= dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            stall   <= 1'b0;
        end else if (complete) begin
            tmo_cnt <= '0;
            stall   <= 1'b0;
        end else if (tmo_cnt < TIMEOUT_CYC) begin
            tmo_cnt <= tmo_cnt + 32'd1;
            stall   <= ((tmo_cnt + 32'd1) >= TIMEOUT_CYC);
        end
    end
endmodule
